// File: rtl/pe_func_unit_multi_ifc_flow_control.sv
// Operand flow control and capture between a PE func unit and NUM_IFC memory units.
// Optional stall counter enabled by defining PE_FUNC_UNIT_IFC_STALL_CNT_EN.

module pe_func_unit_ifc_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifc_en,
    input  logic              instr_done,
    input  logic              memory_unit_rdy,
    input  logic [DATA_W-1:0] mem_data,
    output logic              func_unit_rdy,
    output logic              ifc_unblocked,
    output logic [DATA_W-1:0] operand,
    output logic              done
);
    logic              cap;
    logic [DATA_W-1:0] op_q;

    assign cap           = ifc_en & memory_unit_rdy & ~done;
    assign func_unit_rdy = ifc_en & ~done;
    assign ifc_unblocked = ~ifc_en | done | memory_unit_rdy;
    // Bypass lets the instruction retire in the cycle its last operand arrives.
    assign operand       = cap ? mem_data : op_q;

    // Capture coinciding with instr_done is consumed immediately, so done stays low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            done <= 1'b0;
        else if (instr_done) done <= 1'b0;
        else if (cap)        done <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     op_q <= '0;
        else if (cap) op_q <= mem_data;
    end
endmodule

module pe_func_unit_multi_ifc_flow_control #(
    parameter int NUM_IFC     = 3,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IFC-1:0]        ifc_en,
    input  logic                      instr_done,
    input  logic [NUM_IFC-1:0]        memory_unit_rdy,
    input  logic [NUM_IFC*DATA_W-1:0] mem_data,
    output logic [NUM_IFC-1:0]        func_unit_rdy,
    output logic [NUM_IFC-1:0]        ifc_unblocked,
    output logic                      all_unblocked,
    output logic [NUM_IFC*DATA_W-1:0] operands,
    output logic [NUM_IFC-1:0]        done_vec
`ifdef PE_FUNC_UNIT_IFC_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_cycles
`endif
);
    for (genvar i = 0; i < NUM_IFC; i++) begin : g_lane
        pe_func_unit_ifc_lane #(.DATA_W(DATA_W)) u_lane (
            .clk            (clk),
            .rst            (rst),
            .ifc_en         (ifc_en[i]),
            .instr_done     (instr_done),
            .memory_unit_rdy(memory_unit_rdy[i]),
            .mem_data       (mem_data[i*DATA_W +: DATA_W]),
            .func_unit_rdy  (func_unit_rdy[i]),
            .ifc_unblocked  (ifc_unblocked[i]),
            .operand        (operands[i*DATA_W +: DATA_W]),
            .done           (done_vec[i])
        );

`ifndef SYNTHESIS
        a_dis_idle: assert property (@(posedge clk) disable iff (!rst)
            !ifc_en[i] |-> (ifc_unblocked[i] && !func_unit_rdy[i]))
            else $warning("disabled channel %0d not idle", i);
        a_done_idle: assert property (@(posedge clk) disable iff (!rst)
            done_vec[i] |-> (!func_unit_rdy[i] && ifc_unblocked[i]))
            else $warning("done channel %0d still requesting", i);
`endif
    end

    assign all_unblocked = &ifc_unblocked;

`ifndef SYNTHESIS
    a_retire_unblk: assert property (@(posedge clk) disable iff (!rst)
        instr_done |-> all_unblocked)
        else $warning("instr_done while a channel is blocked");
`endif

`ifdef PE_FUNC_UNIT_IFC_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if ((|ifc_en) && !all_unblocked && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
    end
`else
    logic [31:0] unused_stall_w;
    assign unused_stall_w = 32'(STALL_CNT_W);
`endif
endmodule

// File: doc/pe_func_unit_multi_ifc_flow_control.md
Name: pe_func_unit_multi_ifc_flow_control

Overview:
- Per-operand flow control and operand capture between a PE functional unit and NUM_IFC load/memory units.
- Each channel tracks whether its operand for the current instruction has been received and holds that operand in a register until the parent signals instruction completion.
- Forwards operands combinationally in the arrival cycle, so an instruction can retire in the cycle its last operand arrives.
- Reports aggregate unblocked status to the func unit parent flow control.

Parameters:
- NUM_IFC, 3, number of operand interfaces (channels); minimum 1.
- DATA_W, 32, operand width in bits.
- STALL_CNT_W, 16, stall counter width; used only when PE_FUNC_UNIT_IFC_STALL_CNT_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; reset applies when rst == RESET_STATE (0).
- ifc_en  input  NUM_IFC  per-channel: this instruction needs an operand from channel i.
- instr_done  input  1  parent retires the current instruction this cycle.
- memory_unit_rdy  input  NUM_IFC  per-channel: mem_data slice i is valid.
- mem_data  input  NUM_IFC*DATA_W  operand data; channel i occupies bits [i*DATA_W +: DATA_W].
- func_unit_rdy  output  NUM_IFC  per-channel: func unit accepts data.
- ifc_unblocked  output  NUM_IFC  per-channel: channel not stalling the instruction.
- all_unblocked  output  1  AND of ifc_unblocked.
- operands  output  NUM_IFC*DATA_W  operand values for the func unit.
- done_vec  output  NUM_IFC  registered per-channel done state (debug/observability).
- stall_cycles  output  STALL_CNT_W  present only with PE_FUNC_UNIT_IFC_STALL_CNT_EN.

Behaviour:
- Per channel i, the state bit done[i] has two states: RESET (0) and SET (1).
- cap[i] = ifc_en[i] & memory_unit_rdy[i] & ~done[i].
- func_unit_rdy[i] = ifc_en[i] & ~done[i].
- ifc_unblocked[i] = ~ifc_en[i] | done[i] | memory_unit_rdy[i].
- all_unblocked = &ifc_unblocked. All outputs are combinational from state and inputs.
- done transitions:
  - 0 -> 1 when cap[i] & ~instr_done.
  - 1 -> 0 when instr_done.
  - cap[i] & instr_done in the same cycle: done stays 0, because the operand is consumed in that cycle.
- Operand register op_q[i] loads mem_data slice i when cap[i] is high and holds otherwise. It is not cleared by instr_done.
- Operand output mux: operands slice i = cap[i] ? mem_data slice i : op_q[i] (zero-latency bypass).
- memory_unit_rdy[i] while done[i] = 1 is ignored: no capture and no state change. The memory unit must hold its data until func_unit_rdy is asserted.
- ifc_en deasserted while done[i] = 1 is legal; done clears only on instr_done.
- Reset values: done = 0 and op_q = 0 on all channels, so func_unit_rdy = ifc_en and done_vec = 0. Reset mid-instruction discards captured operands.
- Channels are fully independent; any subset may arrive in any cycle order.
- Protocol assertions (warning severity):
  - instr_done implies all_unblocked.
  - ~ifc_en[i] implies ifc_unblocked[i] & ~func_unit_rdy[i].
  - done[i] implies ~func_unit_rdy[i] & ifc_unblocked[i].

Optional Feature:
- Macro: PE_FUNC_UNIT_IFC_STALL_CNT_EN.
- When defined:
  - stall_cycles increments on every cycle where (|ifc_en) & ~all_unblocked.
  - It saturates at all-ones and clears on reset only.
- When undefined: the port, counter and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with ifc_en=3'b111: func_unit_rdy=3'b111, all_unblocked=0, done_vec=0, operands=0.
- Arrivals on different cycles:
  - Stimulus: ifc_en=3'b111; ch0 data 0xA at cycle 1; ch2 data 0xC at cycle 3; ch1 data 0xB at cycle 5 with instr_done at cycle 5.
  - Response: done_vec=001 after cycle 1 and 101 after cycle 3; all_unblocked=1 only in cycle 5; operands={0xC,0xB,0xA} in cycle 5; done_vec=000 at cycle 6.
- Simultaneous capture and done:
  - Stimulus: ifc_en=3'b001, memory_unit_rdy[0]=1, instr_done=1 in the same cycle, data 0x55.
  - Response: operands[0]=0x55 in that cycle; done[0] stays 0; func_unit_rdy[0]=1 next cycle.
- Duplicate data ignored: after ch1 is done with 0x11, present memory_unit_rdy[1]=1 with 0x22 -> operands[1] stays 0x11 and func_unit_rdy[1]=0.
- Disabled channel and stall counter:
  - Stimulus: ifc_en=3'b010 with ch1 idle for 7 cycles.
  - Response: ifc_unblocked=3'b101; stall_cycles=7 with macro defined; saturation check with STALL_CNT_W=3 gives stall_cycles=7 after 10 stall cycles.
- Async reset mid-instruction: rst low while done_vec=011 -> done_vec=000 immediately, without waiting for a clock edge.
